// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one async FIFO write port among
//            NUM_REQ write-domain requesters; words are tagged with the source.
// Revision : 1.0 - initial release
// =============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_BURST  = 4,
    parameter int MIN_SPACE  = 1,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_we_o,
    output logic [IDW+DATA_WIDTH-1:0]     fifo_wdata_o,
    input  logic                          fifo_full_i,
    input  logic [ADDR_WIDTH:0]           fifo_wfill_count_i,
    output logic                          busy_o,
    output logic [IDW-1:0]                grant_idx_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int BCW   = $clog2(MAX_BURST+1);

    localparam logic [ADDR_WIDTH:0] c_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_MIN_SPACE = (ADDR_WIDTH+1)'(MIN_SPACE);
    localparam logic [BCW-1:0]      c_LAST_BEAT = BCW'(MAX_BURST-1);
    localparam logic [IDW-1:0]      c_LAST_REQ  = IDW'(NUM_REQ-1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;

    logic [ADDR_WIDTH:0]  w_free;
    logic                 w_space_ok;
    logic [IDW-1:0]       w_idx;
    logic [IDW-1:0]       w_pick;
    logic                 w_pick_vld;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                 w_beat;
    logic                 w_burst_end;

    // The fill count lags the real FIFO occupancy; it only gates burst start.
    assign w_free     = c_DEPTH - fifo_wfill_count_i;
    assign w_space_ok = (w_free >= c_MIN_SPACE) && !fifo_full_i;

    always_comb begin
        w_idx      = '0;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!w_pick_vld && req_valid_i[w_idx]) begin
                w_pick     = w_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                w_sel_data     = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready_o[i] = (state_q == ST_BURST) && !fifo_full_i;
            end
        end
    end

    assign w_beat       = (state_q == ST_BURST) && req_valid_i[grant_q] && !fifo_full_i;
    assign w_burst_end  = w_beat && (req_last_i[grant_q] || (beat_cnt_q == c_LAST_BEAT));
    assign fifo_we_o    = w_beat;
    assign fifo_wdata_o = {grant_q, w_sel_data};
    assign busy_o       = (state_q == ST_BURST);
    assign grant_idx_o  = grant_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_vld && w_space_ok) begin
                    state_d    = ST_BURST;
                    grant_d    = w_pick;
                    beat_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (w_beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (w_burst_end) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_q == c_LAST_REQ) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Scoreboard bench for fifo_wr_arbiter (MIN_SPACE = 4 build).
// Revision : 1.0 - initial release
// =============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int AW      = 3;
    localparam int IDW     = 2;

    logic                    clk = 1'b0;
    logic                    rst_i;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ*DW-1:0]   req_data_i;
    logic [NUM_REQ-1:0]      req_last_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic                    fifo_we_o;
    logic [IDW+DW-1:0]       fifo_wdata_o;
    logic                    fifo_full_i;
    logic [AW:0]             fifo_wfill_count_i;
    logic                    busy_o;
    logic [IDW-1:0]          grant_idx_o;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (4),
        .MIN_SPACE  (4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_data_i         (req_data_i),
        .req_last_i         (req_last_i),
        .req_ready_o        (req_ready_o),
        .fifo_we_o          (fifo_we_o),
        .fifo_wdata_o       (fifo_wdata_o),
        .fifo_full_i        (fifo_full_i),
        .fifo_wfill_count_i (fifo_wfill_count_i),
        .busy_o             (busy_o),
        .grant_idx_o        (grant_idx_o)
    );

    // Requester models: words left, forced-idle flag, last-marking, sequence no.
    int  cnt  [NUM_REQ];
    bit  hold [NUM_REQ];
    bit  lastm[NUM_REQ];
    int  seq  [NUM_REQ];

    logic [IDW+DW-1:0] exp_q[$];

    logic               busy_a [64];
    logic               we_a   [64];
    logic [IDW-1:0]     grant_a[64];
    logic [NUM_REQ-1:0] rdy_a  [64];
    int k;
    int nwr;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [IDW+DW-1:0] word(input int i, input int s);
        return {IDW'(i), 8'(i), 24'(s)};
    endfunction

    task automatic push(input int i, input int first, input int n);
        for (int s = first; s < first + n; s++) exp_q.push_back(word(i, s));
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid_i[i]            = (cnt[i] > 0) && !hold[i];
            req_last_i[i]             = lastm[i] && (cnt[i] == 1);
            req_data_i[i*DW +: DW]    = {8'(i), 24'(seq[i])};
        end
    endtask

    // One clock: drive, sample mid-cycle, score writes, advance on handshakes.
    task automatic cyc();
        logic [NUM_REQ-1:0] acc;
        logic               rs;
        logic [IDW+DW-1:0]  ew;
        drive();
        @(negedge clk);
        rs = rst_i;
        acc = req_valid_i & req_ready_o;
        busy_a[k]  = busy_o;
        we_a[k]    = fifo_we_o;
        grant_a[k] = grant_idx_o;
        rdy_a[k]   = req_ready_o;
        if (!rs && fifo_we_o) begin
            nwr++;
            ew = 'x;
            if (exp_q.size() > 0) ew = exp_q.pop_front();
            chk("wdata", 64'(fifo_wdata_o), 64'(ew));
        end
        @(posedge clk);
        #1;
        if (!rs) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    cnt[i]--;
                end
            end
        end
        k++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] = 0; hold[i] = 1'b0; lastm[i] = 1'b0; seq[i] = 0;
        end
        fifo_full_i        = 1'b0;
        fifo_wfill_count_i = '0;
        rst_i = 1'b1;
        k = 0;
        cyc();
        cyc();
        rst_i = 1'b0;
        exp_q.delete();
        k   = 0;
        nwr = 0;
    endtask

    task automatic finish_scn(input string tag, input int n_exp);
        chk({tag, "_nwr"}, 64'(nwr), 64'(n_exp));
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst_i              = 1'b1;
        req_valid_i        = '0;
        req_data_i         = '0;
        req_last_i         = '0;
        fifo_full_i        = 1'b0;
        fifo_wfill_count_i = '0;

        // Reset state
        do_reset();
        cyc();
        chk("rst_busy",  64'(busy_a[0]),  64'(0));
        chk("rst_we",    64'(we_a[0]),    64'(0));
        chk("rst_grant", 64'(grant_a[0]), 64'(0));
        chk("rst_ready", 64'(rdy_a[0]),   64'(0));

        // Single requester, 3 words with last
        do_reset();
        cnt[0] = 3; lastm[0] = 1'b1;
        push(0, 0, 3);
        repeat (6) cyc();
        chk("s1_idle0", 64'(busy_a[0]), 64'(0));
        chk("s1_busy1", 64'(busy_a[1]), 64'(1));
        chk("s1_gnt1",  64'(grant_a[1]), 64'(0));
        for (int j = 1; j <= 3; j++) chk("s1_we", 64'(we_a[j]), 64'(1));
        chk("s1_end_busy", 64'(busy_a[4]), 64'(0));
        chk("s1_end_we",   64'(we_a[4]),   64'(0));
        chk("s1_rr_ptr",   64'(dut.rr_ptr_q), 64'(1));
        finish_scn("s1", 3);

        // All requesters streaming, bursts capped at 4
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 100;
        for (int i = 0; i < NUM_REQ; i++) push(i, 0, 4);
        push(0, 4, 4);
        repeat (25) cyc();
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        for (int b = 0; b < 5; b++) chk("s2_gnt", 64'(grant_a[1+5*b]), 64'(b % 4));
        for (int b = 0; b < 4; b++) begin
            chk("s2_gap_busy", 64'(busy_a[5+5*b]), 64'(0));
            chk("s2_gap_we",   64'(we_a[5+5*b]),   64'(0));
        end
        finish_scn("s2", 20);

        // FIFO full for 3 cycles during beat 2
        do_reset();
        cnt[0] = 4;
        push(0, 0, 4);
        for (int j = 0; j < 10; j++) begin
            fifo_full_i = (j >= 2) && (j <= 4);
            cyc();
        end
        fifo_full_i = 1'b0;
        chk("s3_beat1", 64'(we_a[1]), 64'(1));
        for (int j = 2; j <= 4; j++) begin
            chk("s3_full_we",   64'(we_a[j]),    64'(0));
            chk("s3_full_rdy",  64'(rdy_a[j]),   64'(0));
            chk("s3_full_gnt",  64'(grant_a[j]), 64'(0));
            chk("s3_full_busy", 64'(busy_a[j]),  64'(1));
        end
        for (int j = 5; j <= 7; j++) chk("s3_resume_we", 64'(we_a[j]), 64'(1));
        chk("s3_end_busy", 64'(busy_a[8]), 64'(0));
        finish_scn("s3", 4);

        // Space gate: free 3, then 0, then 4
        do_reset();
        cnt[2] = 2; lastm[2] = 1'b1;
        push(2, 0, 2);
        for (int j = 0; j < 7; j++) begin
            fifo_wfill_count_i = (j < 2) ? 4'd5 : ((j == 2) ? 4'd8 : 4'd4);
            cyc();
        end
        fifo_wfill_count_i = '0;
        for (int j = 0; j <= 3; j++) begin
            chk("s4_hold_busy", 64'(busy_a[j]), 64'(0));
            chk("s4_hold_we",   64'(we_a[j]),   64'(0));
        end
        chk("s4_gnt_busy", 64'(busy_a[4]),  64'(1));
        chk("s4_gnt_idx",  64'(grant_a[4]), 64'(2));
        chk("s4_end_busy", 64'(busy_a[6]),  64'(0));
        finish_scn("s4", 2);

        // Granted requester stalls while another waits
        do_reset();
        cnt[1] = 3; lastm[1] = 1'b1;
        cnt[3] = 2; lastm[3] = 1'b1;
        push(1, 0, 3);
        push(3, 0, 2);
        for (int j = 0; j < 13; j++) begin
            hold[1] = (j >= 2) && (j <= 6);
            cyc();
        end
        chk("s5_gnt1", 64'(grant_a[1]), 64'(1));
        for (int j = 2; j <= 6; j++) begin
            chk("s5_gap_we",   64'(we_a[j]),    64'(0));
            chk("s5_gap_gnt",  64'(grant_a[j]), 64'(1));
            chk("s5_gap_busy", 64'(busy_a[j]),  64'(1));
        end
        chk("s5_resume_we", 64'(we_a[7]),    64'(1));
        chk("s5_idle",      64'(busy_a[9]),  64'(0));
        chk("s5_gnt3",      64'(grant_a[10]), 64'(3));
        chk("s5_busy3",     64'(busy_a[10]), 64'(1));
        chk("s5_end",       64'(busy_a[12]), 64'(0));
        finish_scn("s5", 5);

        // Reset during beat 2 of a burst after rr_ptr has moved
        do_reset();
        cnt[1] = 1; lastm[1] = 1'b1;
        push(1, 0, 1);
        push(2, 0, 1);
        push(0, 0, 1);
        for (int j = 0; j < 7; j++) begin
            if (j == 2) cnt[2] = 100;
            if (j == 5) cnt[0] = 100;
            rst_i = (j == 4);
            cyc();
        end
        chk("s6_gnt2",     64'(grant_a[3]), 64'(2));
        chk("s6_post_we",  64'(we_a[5]),    64'(0));
        chk("s6_post_busy", 64'(busy_a[5]), 64'(0));
        chk("s6_rr_ptr",   64'(dut.rr_ptr_q), 64'(0));
        chk("s6_gnt0",     64'(grant_a[6]), 64'(0));
        chk("s6_busy0",    64'(busy_a[6]),  64'(1));
        finish_scn("s6", 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
